// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/forward control with a multi-cycle EX watchdog.
// Define PIPE_HAZARD_CTRL_FWD_EN for EX operand forwarding; otherwise RAW hazards stall in ID.
module pipe_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_useRs1,
  input  logic        id_useRs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_writeReg,
  input  logic        ex_memRead,
  input  logic [4:0]  me_rd,
  input  logic        me_writeReg,
  input  logic [4:0]  wb_rd,
  input  logic        wb_writeReg,
  input  logic        ex_branchTaken,
  input  logic        ex_mdStart,
  input  logic        md_done,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_me_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        md_timeout,
  output logic [15:0] stall_cnt
);
  typedef enum logic {RUN, MDBUSY} state_t;
  state_t state, stateNext;
  logic [7:0] mdCnt;
  logic loadUse, rawHaz, hazard, wdHit, timeoutSet;
  logic pcStall, ifIdStall, idExStall, ifIdFlush, idExFlush, exMeFlush;
  logic [1:0] fwdA, fwdB;
  assign loadUse = ex_memRead && ex_writeReg && ex_rd != 5'd0 &&
                   ((id_useRs1 && id_rs1 == ex_rd) || (id_useRs2 && id_rs2 == ex_rd));
`ifdef PIPE_HAZARD_CTRL_FWD_EN
  assign fwdA = (me_writeReg && me_rd != 5'd0 && me_rd == ex_rs1) ? 2'b01 :
                (wb_writeReg && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
  assign fwdB = (me_writeReg && me_rd != 5'd0 && me_rd == ex_rs2) ? 2'b01 :
                (wb_writeReg && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
  assign rawHaz = 1'b0;
`else
  logic rs1Raw, rs2Raw, unusedExRs;
  // Without forwarding, any in-flight writer of an ID source must drain before ID proceeds.
  assign rs1Raw = id_useRs1 && id_rs1 != 5'd0 &&
                  ((ex_writeReg && id_rs1 == ex_rd) || (me_writeReg && id_rs1 == me_rd) ||
                   (wb_writeReg && id_rs1 == wb_rd));
  assign rs2Raw = id_useRs2 && id_rs2 != 5'd0 &&
                  ((ex_writeReg && id_rs2 == ex_rd) || (me_writeReg && id_rs2 == me_rd) ||
                   (wb_writeReg && id_rs2 == wb_rd));
  assign rawHaz = rs1Raw || rs2Raw;
  assign fwdA = 2'b00;
  assign fwdB = 2'b00;
  assign unusedExRs = ^{ex_rs1, ex_rs2};
`endif
  assign hazard = loadUse || rawHaz;
  assign wdHit = mdCnt == 8'(MD_MAX_CYCLES - 1);
  always_comb begin
    stateNext = state;
    {pcStall, ifIdStall, idExStall, ifIdFlush, idExFlush, exMeFlush} = 6'b0;
    timeoutSet = 1'b0;
    if (state == RUN) begin
      if (ex_mdStart) stateNext = MDBUSY;
      else if (ex_branchTaken) {ifIdFlush, idExFlush} = 2'b11;
      else if (hazard) {pcStall, ifIdStall, idExFlush} = 3'b111;
    end else if (md_done) begin
      stateNext = RUN;
    end else begin
      {pcStall, ifIdStall, idExStall, exMeFlush} = 4'hF;
      stateNext = wdHit ? RUN : MDBUSY;
      timeoutSet = wdHit;
    end
  end
  // Combinational outputs are forced quiet while reset is held.
  assign pc_stall    = rst && pcStall;
  assign if_id_stall = rst && ifIdStall;
  assign id_ex_stall = rst && idExStall;
  assign if_id_flush = rst && ifIdFlush;
  assign id_ex_flush = rst && idExFlush;
  assign ex_me_flush = rst && exMeFlush;
  assign fwd_a = rst ? fwdA : 2'b00;
  assign fwd_b = rst ? fwdB : 2'b00;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      mdCnt      <= 8'd0;
      stall_cnt  <= 16'd0;
      md_timeout <= 1'b0;
    end else begin
      state      <= stateNext;
      mdCnt      <= (state == RUN) ? 8'd0 : mdCnt + 8'd1;
      stall_cnt  <= stall_cnt + {15'd0, pcStall && stall_cnt != 16'hFFFF};
      md_timeout <= md_timeout || timeoutSet;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard, branch, multi-cycle, watchdog and forwarding control.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd;
  logic id_useRs1, id_useRs2, ex_writeReg, ex_memRead, me_writeReg, wb_writeReg;
  logic ex_branchTaken, ex_mdStart, md_done;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_me_flush, md_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic wPcStall, wIfIdStall, wIdExStall, wIfIdFlush, wIdExFlush, wExMeFlush, wTimeout;
  logic [1:0] wFwdA, wFwdB;
  logic [15:0] wStallCnt;
  logic [5:0] ctl, ctlW;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign ctl  = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_me_flush};
  assign ctlW = {wPcStall, wIfIdStall, wIdExStall, wIfIdFlush, wIdExFlush, wExMeFlush};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1),
    .id_useRs2(id_useRs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_writeReg(ex_writeReg), .ex_memRead(ex_memRead), .me_rd(me_rd), .me_writeReg(me_writeReg),
    .wb_rd(wb_rd), .wb_writeReg(wb_writeReg), .ex_branchTaken(ex_branchTaken),
    .ex_mdStart(ex_mdStart), .md_done(md_done), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_me_flush(ex_me_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_MAX_CYCLES(4)) dutW (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1),
    .id_useRs2(id_useRs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_writeReg(ex_writeReg), .ex_memRead(ex_memRead), .me_rd(me_rd), .me_writeReg(me_writeReg),
    .wb_rd(wb_rd), .wb_writeReg(wb_writeReg), .ex_branchTaken(ex_branchTaken),
    .ex_mdStart(ex_mdStart), .md_done(md_done), .pc_stall(wPcStall), .if_id_stall(wIfIdStall),
    .id_ex_stall(wIdExStall), .if_id_flush(wIfIdFlush), .id_ex_flush(wIdExFlush),
    .ex_me_flush(wExMeFlush), .fwd_a(wFwdA), .fwd_b(wFwdB), .md_timeout(wTimeout),
    .stall_cnt(wStallCnt)
  );

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd} = '0;
    {id_useRs1, id_useRs2, ex_writeReg, ex_memRead, me_writeReg, wb_writeReg} = '0;
    {ex_branchTaken, ex_mdStart, md_done} = '0;
  endtask

  task automatic set_load_use();
    idle();
    ex_memRead = 1'b1; ex_writeReg = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_useRs1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_load_use();
    me_writeReg = 1'b1; me_rd = 5'd7; ex_rs1 = 5'd7;
    #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b0); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", md_timeout); end
    @(negedge clk); rst = 1'b1; idle(); #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL idle_ctl: got %b expected %b", ctl, 6'b0); end
  endtask

  task automatic test_load_use();
    @(negedge clk); set_load_use(); #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL loaduse_ctl: got %b expected %b", ctl, 6'b110010); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL loaduse_release: got %b expected %b", ctl, 6'b0); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL loaduse_cnt: got %0d expected 1", stall_cnt); end
    @(negedge clk); set_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL loaduse_x0: got %b expected %b", ctl, 6'b0); end
  endtask

  task automatic test_branch();
    @(negedge clk); set_load_use(); ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL branch_over_loaduse: got %b expected %b", ctl, 6'b000110); end
    @(negedge clk); idle(); ex_branchTaken = 1'b1; md_done = 1'b1; #1;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL branch_plain: got %b expected %b", ctl, 6'b000110); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL branch_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_raw();
    logic [5:0] expStall;
    expStall = FWD ? 6'b0 : 6'b110010;
    @(negedge clk); idle(); me_writeReg = 1'b1; me_rd = 5'd9; id_rs2 = 5'd9; id_useRs2 = 1'b1; #1;
    checks++; if (ctl !== expStall) begin errors++; $display("FAIL raw_me: got %b expected %b", ctl, expStall); end
    @(negedge clk); #1;
    checks++; if (ctl !== expStall) begin errors++; $display("FAIL raw_me_hold: got %b expected %b", ctl, expStall); end
    @(negedge clk); id_useRs2 = 1'b0; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL raw_nouse: got %b expected %b", ctl, 6'b0); end
    @(negedge clk); idle(); wb_writeReg = 1'b1; wb_rd = 5'd3; id_rs1 = 5'd3; id_useRs1 = 1'b1; #1;
    checks++; if (ctl !== expStall) begin errors++; $display("FAIL raw_wb: got %b expected %b", ctl, expStall); end
    @(negedge clk); idle(); ex_writeReg = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_useRs1 = 1'b1; #1;
    checks++; if (ctl !== expStall) begin errors++; $display("FAIL raw_ex_alu: got %b expected %b", ctl, expStall); end
    @(negedge clk); idle(); wb_writeReg = 1'b1; id_useRs1 = 1'b1; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL raw_x0: got %b expected %b", ctl, 6'b0); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== (FWD ? 16'd1 : 16'd5)) begin errors++; $display("FAIL raw_cnt: got %0d expected %0d", stall_cnt, FWD ? 1 : 5); end
  endtask

  task automatic test_fwd();
    @(negedge clk); idle();
    me_writeReg = 1'b1; wb_writeReg = 1'b1; me_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; #1;
    checks++; if (fwd_a !== (FWD ? 2'b01 : 2'b00)) begin errors++; $display("FAIL fwd_me_prio: got %b expected %b", fwd_a, FWD ? 2'b01 : 2'b00); end
    ex_rs1 = 5'd0; ex_rs2 = 5'd3; wb_rd = 5'd3; #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", fwd_a); end
    checks++; if (fwd_b !== (FWD ? 2'b10 : 2'b00)) begin errors++; $display("FAIL fwd_wb_b: got %b expected %b", fwd_b, FWD ? 2'b10 : 2'b00); end
    me_rd = 5'd0; wb_rd = 5'd0; #1;
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_rd0: got %b expected 00", fwd_b); end
  endtask

  task automatic test_watchdog();
    logic [15:0] s0;
    s0 = wStallCnt;
    checks++; if (wTimeout !== 1'b0) begin errors++; $display("FAIL wd_pre: got %b expected 0", wTimeout); end
    @(negedge clk); idle(); ex_mdStart = 1'b1; #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); idle(); #1;
      checks++; if (ctlW !== 6'b111001) begin errors++; $display("FAIL wd_busy%0d: got %b expected %b", k, ctlW, 6'b111001); end
    end
    @(negedge clk); #1;
    checks++; if (ctlW !== 6'b0) begin errors++; $display("FAIL wd_run: got %b expected %b", ctlW, 6'b0); end
    checks++; if (wTimeout !== 1'b1) begin errors++; $display("FAIL wd_flag: got %b expected 1", wTimeout); end
    checks++; if (wStallCnt !== s0 + 16'd4) begin errors++; $display("FAIL wd_cnt: got %0d expected %0d", wStallCnt, s0 + 16'd4); end
    @(negedge clk); md_done = 1'b1; #1;
    checks++; if (ctlW !== 6'b0) begin errors++; $display("FAIL wd_done_ignored: got %b expected %b", ctlW, 6'b0); end
    @(negedge clk); idle(); #1;
    checks++; if (wTimeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", wTimeout); end
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL wd_main_run: got %b expected %b", ctl, 6'b0); end
    checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL wd_main_flag: got %b expected 0", md_timeout); end
  endtask

  task automatic test_md_op();
    logic [15:0] s0;
    s0 = stall_cnt;
    @(negedge clk); idle(); ex_mdStart = 1'b1; ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL md_start_wins: got %b expected %b", ctl, 6'b0); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); set_load_use(); ex_branchTaken = 1'b1; ex_mdStart = (k == 2); #1;
      checks++; if (ctl !== 6'b111001) begin errors++; $display("FAIL md_busy%0d: got %b expected %b", k, ctl, 6'b111001); end
    end
    @(negedge clk); idle(); md_done = 1'b1; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL md_done_ctl: got %b expected %b", ctl, 6'b0); end
    @(negedge clk); idle(); md_done = 1'b1; ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL md_back_run: got %b expected %b", ctl, 6'b000110); end
    checks++; if (stall_cnt !== s0 + 16'd9) begin errors++; $display("FAIL md_cnt: got %0d expected %0d", stall_cnt, s0 + 16'd9); end
    checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL md_no_timeout: got %b expected 0", md_timeout); end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk); idle(); ex_mdStart = 1'b1;
    @(negedge clk); idle();
    @(negedge clk); #1;
    checks++; if (ctl !== 6'b111001) begin errors++; $display("FAIL rmid_busy: got %b expected %b", ctl, 6'b111001); end
    @(negedge clk); rst = 1'b0; set_load_use(); ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rmid_ctl: got %b expected %b", ctl, 6'b0); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (wTimeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout: got %b expected 0", wTimeout); end
    @(negedge clk); rst = 1'b1; idle(); #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rmid_after: got %b expected %b", ctl, 6'b0); end
    @(negedge clk); ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL rmid_run: got %b expected %b", ctl, 6'b000110); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmid_nostall: got %0d expected 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_raw();
    test_fwd();
    test_watchdog();
    test_md_op();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
